// File: rtl/framing_pkg.sv
// framing_pkg: shared framing constants, serialiser state type and index-width helper
package framing_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OUT_W = 1;
  localparam int DEF_DEPTH = 16;
  function automatic int idx_w(input int chunks);
    return chunks > 1 ? $clog2(chunks) : 1;
  endfunction
endpackage

// File: rtl/fifo_storage.sv
// fifo_storage: circular word store with wrapping pointers, occupancy count and full/empty flags
module fifo_storage #(
  parameter int W = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  // pointers wrap modulo DEPTH; count carries one extra bit so it can reach DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  // payload array needs no reset: contents are only read behind a non-zero count
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/serial_frame_fifo.sv
// serial_frame_fifo: buffers tagged words and serialises them into chunks with backpressure and frame-end pulses
module serial_frame_fifo
  import framing_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      fifo_input,
  input  logic                   fifo_input_valid,
  input  logic                   fifo_input_last,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [OUT_W-1:0]       fifo_output,
  output logic                   fifo_output_valid,
  input  logic                   fifo_output_ready,
  output logic                   data_end,
  output logic                   overflow
);
  localparam int CHUNKS = DATA_W / OUT_W;
  localparam int IW = idx_w(CHUNKS);
  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_last;
  logic [IW-1:0]     r_idx;
  logic              r_data_end;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_final;
  logic              w_empty;
  logic [DATA_W:0]   w_head;
  logic [31:0]       w_lo;
  // full is sampled before any same-cycle pop, so a write while full is always refused
  assign w_push  = fifo_input_valid && !fifo_full;
  assign w_hs    = (r_state == SHIFT) && fifo_output_ready;
  assign w_final = r_idx == IW'(CHUNKS - 1);
  assign w_pop   = !w_empty && ((r_state == IDLE) || (w_hs && w_final));
  fifo_storage #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({fifo_input_last, fifo_input}),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (w_empty)
  );
  // loading always means SHIFT; finishing the last chunk with nothing queued falls back to IDLE
  always_comb begin
    w_next = w_pop ? SHIFT : (w_hs && w_final) ? IDLE : r_state;
  end
  // serialiser state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // shifter loads on pop and otherwise advances its chunk index on each accepted non-final chunk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= w_head[DATA_W-1:0];
      r_last  <= w_head[DATA_W];
      r_idx   <= '0;
    end else if (w_hs && !w_final) begin
      r_idx <= r_idx + 1'b1;
    end
  end
  // frame-end pulse follows acceptance of the final chunk of a tagged word; overflow is sticky
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_end <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_data_end <= w_hs && w_final && r_last;
      r_overflow <= r_overflow || (fifo_input_valid && fifo_full);
    end
  end
  assign w_lo = LSB_FIRST != 0 ? 32'(OUT_W * int'(r_idx)) : 32'(DATA_W - OUT_W * (int'(r_idx) + 1));
  assign fifo_output_valid = r_state == SHIFT;
  assign fifo_output = fifo_output_valid ? OUT_W'(r_shift >> w_lo) : '0;
  assign data_end = r_data_end;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_serial_frame_fifo.sv
// tb_serial_frame_fifo: scoreboard bench driving four FIFO configurations from one shared stimulus stream
module tb_serial_frame_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = '0;
  logic       vld = 1'b0;
  logic       lst = 1'b0;
  logic       rdy = 1'b1;
  int         n_checks = 0;
  int         n_errs = 0;
  localparam int OW [4] = '{1, 4, 4, 1};
  localparam int LF [4] = '{1, 0, 1, 1};
  localparam int DP [4] = '{16, 16, 16, 4};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  genvar k;
  for (k = 0; k < 4; k++) begin : g
    localparam int O = OW[k];
    localparam int L = LF[k];
    localparam int D = DP[k];
    localparam int C = 8 / O;
    localparam int CW = $clog2(D) + 1;
    logic          f;
    logic [CW-1:0] cnt;
    logic [O-1:0]  q;
    logic          v;
    logic          de;
    logic          ov;
    logic [4:0]    exq[$];
    int            mcount = 0;
    int            mrem = 0;
    bit            mbusy = 0;
    bit            mov = 0;
    bit            mde = 0;

    serial_frame_fifo #(.DATA_W(8), .OUT_W(O), .DEPTH(D), .LSB_FIRST(L)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .fifo_input        (din),
      .fifo_input_valid  (vld),
      .fifo_input_last   (lst),
      .fifo_full         (f),
      .fifo_count        (cnt),
      .fifo_output       (q),
      .fifo_output_valid (v),
      .fifo_output_ready (rdy),
      .data_end          (de),
      .overflow          (ov)
    );

    always @(negedge clk) begin
      bit hs, fin, acc, pop;
      if (!reset_n) begin
        exq.delete();
        mcount = 0;
        mrem = 0;
        mbusy = 0;
        mov = 0;
        mde = 0;
        chk("rst_valid", 32'(v), 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_data_end", 32'(de), 0);
        chk("rst_output", 32'(q), 0);
        chk("rst_full", 32'(f), 0);
        chk("rst_overflow", 32'(ov), 0);
      end else begin
        chk("valid", 32'(v), 32'(mbusy));
        chk("count", 32'(cnt), 32'(mcount));
        chk("full", 32'(f), 32'(mcount == D));
        chk("overflow", 32'(ov), 32'(mov));
        chk("data_end", 32'(de), 32'(mde));
        if (!v) chk("idle_output", 32'(q), 0);
        else if (exq.size() == 0) chk("chunk_pending", 32'(exq.size() > 0), 1);
        else chk("chunk", 32'(q), 32'(exq[0][3:0]));
        hs = mbusy && rdy;
        fin = hs && mrem == 1;
        mde = hs && exq.size() > 0 && exq[0][4];
        if (hs && exq.size() > 0) void'(exq.pop_front());
        if (vld && mcount == D) mov = 1;
        acc = vld && mcount != D;
        pop = mcount > 0 && (!mbusy || fin);
        if (pop) begin
          mbusy = 1;
          mrem = C;
        end else if (fin) mbusy = 0;
        else if (hs) mrem--;
        mcount = mcount + int'(acc) - int'(pop);
        if (acc)
          for (int i = 0; i < C; i++)
            exq.push_back({i == C - 1 && lst, 4'((din >> ((L != 0 ? i : C - 1 - i) * O)) & 8'((1 << O) - 1))});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    lst = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic put(input logic [7:0] w, input logic l);
    din = w;
    vld = 1'b1;
    lst = l;
    cyc();
  endtask

  task automatic pulse_reset();
    vld = 1'b0;
    reset_n = 1'b0;
    #20;
    reset_n = 1'b1;
    cyc();
  endtask

  logic [7:0] s1 [8] = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
  logic [3:0] bp = 4'b1001;

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) put(s1[i], i == 7);
    idle(80);
    pulse_reset();
    put(8'h21, 1'b0);
    put(8'h43, 1'b1);
    idle(20);
    pulse_reset();
    for (int c = 0; c < 200; c++) begin
      rdy = bp[3 - (c % 4)];
      if (c < 8) put(s1[c], c == 7);
      else begin
        vld = 1'b0;
        cyc();
      end
    end
    rdy = 1'b1;
    idle(20);
    pulse_reset();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h10 + 8'(i), i == 5);
    idle(4);
    rdy = 1'b1;
    idle(60);
    pulse_reset();
    put(8'hA5, 1'b1);
    idle(3);
    pulse_reset();
    put(8'h3C, 1'b1);
    idle(15);
    put(8'hAA, 1'b1);
    put(8'h55, 1'b1);
    idle(25);
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom % 4) != 0;
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else if ($urandom % 3 != 0) put(8'($urandom), ($urandom % 4) == 0);
      else idle(1);
    end
    rdy = 1'b1;
    idle(300);
    chk("drained0", 32'(g[0].exq.size()), 0);
    chk("drained1", 32'(g[1].exq.size()), 0);
    chk("drained2", 32'(g[2].exq.size()), 0);
    chk("drained3", 32'(g[3].exq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
